// File: rtl/mac_psum_acc.sv
// mac_psum_acc: per-column partial-sum accumulator that sits after the systolic
// MAC array. Each group of beats is summed per lane (saturating), then a
// per-lane bias is added, followed by a rounding arithmetic right shift, an
// optional ReLU and saturation to OUTW bits. Finished groups are queued in a
// DEPTH-entry FIFO.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   acc_m_data         COLUMN lanes of IW-bit signed partial sums
//   acc_m_first/last   group framing; acc_m_valid/acc_m_ready beat handshake
//   bias, shift,       per-group post-processing controls, sampled on the
//   relu_en            accepted last beat
//   acc_s_data         COLUMN lanes of OUTW-bit signed results (FIFO head)
//   acc_s_sat          saturation seen anywhere in the head group
//   acc_s_valid/ready  result handshake toward writeback
module mac_psum_acc #(
    parameter int COLUMN = 6,
    parameter int IW     = 24,
    parameter int BW     = 24,
    parameter int AW     = 32,
    parameter int OUTW   = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLUMN*IW-1:0]     acc_m_data,
    input  logic                     acc_m_first,
    input  logic                     acc_m_last,
    input  logic                     acc_m_valid,
    output logic                     acc_m_ready,
    input  logic [COLUMN*BW-1:0]     bias,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic [COLUMN*OUTW-1:0]   acc_s_data,
    output logic                     acc_s_sat,
    output logic                     acc_s_valid,
    input  logic                     acc_s_ready
);
    // Post-stage width: AW+1 for acc+bias, one more bit of headroom for the
    // rounding constant.
    localparam int PW   = AW + 2;
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic signed [PW-1:0] OUT_MAX = PW'((2 ** (OUTW - 1)) - 1);
    localparam logic signed [PW-1:0] OUT_MIN = PW'(-(2 ** (OUTW - 1)));

    // Returns {overflow, saturated sum}.
    function automatic logic [AW:0] acc_add(input logic signed [AW-1:0] a,
                                            input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s[AW] != s[AW-1])
            return s[AW] ? {1'b1, 1'b1, {(AW-1){1'b0}}} : {1'b1, 1'b0, {(AW-1){1'b1}}};
        return {1'b0, s[AW-1:0]};
    endfunction

    // Round half up, then arithmetic shift; shift of zero passes through.
    function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] v,
                                                         input logic [4:0] sh);
        logic signed [PW-1:0] half;
        if (sh == 5'd0)
            return v;
        half = PW'(1) << (sh - 5'd1);
        return (v + half) >>> sh;
    endfunction

    // Returns {saturated, OUTW-bit value}.
    function automatic logic [OUTW:0] sat_out(input logic signed [PW-1:0] v);
        if (v > OUT_MAX)
            return {1'b1, OUT_MAX[OUTW-1:0]};
        if (v < OUT_MIN)
            return {1'b1, OUT_MIN[OUTW-1:0]};
        return {1'b0, v[OUTW-1:0]};
    endfunction

    logic signed [AW-1:0]   acc_q [COLUMN];
    logic signed [AW-1:0]   acc_d [COLUMN];
    logic signed [AW-1:0]   lane_ext [COLUMN];
    logic [AW:0]            add_r [COLUMN];
    logic [COLUMN-1:0]      acc_sat_q, acc_sat_d;
    logic signed [PW-1:0]   sum_d [COLUMN];
    logic signed [PW-1:0]   sum_p0 [COLUMN];
    logic [4:0]             shift_p0;
    logic                   relu_p0, sat_p0, vld_p0;
    logic signed [PW-1:0]   rs_d [COLUMN];
    logic [OUTW:0]          so_d [COLUMN];
    logic [COLUMN*OUTW-1:0] data_d1, data_p1;
    logic                   sat_d1, sat_p1, vld_p1;
    logic [COLUMN*OUTW:0]   mem_q [DEPTH];
    logic [PTRW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          cnt_q;
    logic [CW:0]            inflight;
    logic                   beat_acc, last_acc, fifo_rd;

    // Everything past the accumulator counts against FIFO space, so an
    // accepted last beat always finds a free entry when it arrives.
    assign inflight    = {1'b0, cnt_q} + {{CW{1'b0}}, vld_p0} + {{CW{1'b0}}, vld_p1};
    assign acc_m_ready = inflight < (CW + 1)'(DEPTH);
    assign beat_acc    = acc_m_valid && acc_m_ready;
    assign last_acc    = beat_acc && acc_m_last;
    assign acc_s_valid = (cnt_q != '0);
    assign fifo_rd     = acc_s_valid && acc_s_ready;
    assign acc_s_data  = mem_q[rd_ptr_q][COLUMN*OUTW-1:0];
    assign acc_s_sat   = mem_q[rd_ptr_q][COLUMN*OUTW];

    // Stage: accumulate, and form acc+bias from the updated accumulator
    always_comb begin
        acc_sat_d = acc_sat_q;
        for (int c = 0; c < COLUMN; c++) begin
            lane_ext[c] = AW'(signed'(acc_m_data[c*IW +: IW]));
            add_r[c]    = acc_add(acc_q[c], lane_ext[c]);
            acc_d[c]    = acc_q[c];
            if (beat_acc) begin
                if (acc_m_first) begin
                    acc_d[c]     = lane_ext[c];
                    acc_sat_d[c] = 1'b0;
                end else begin
                    acc_d[c]     = add_r[c][AW-1:0];
                    acc_sat_d[c] = acc_sat_q[c] | add_r[c][AW];
                end
            end
            sum_d[c] = PW'(acc_d[c]) + PW'(signed'(bias[c*BW +: BW]));
        end
    end

    // Stage p0 -> p1: round/shift, ReLU, output saturation
    always_comb begin
        data_d1 = '0;
        sat_d1  = sat_p0;
        for (int c = 0; c < COLUMN; c++) begin
            rs_d[c] = round_shift(sum_p0[c], shift_p0);
            if (relu_p0 && rs_d[c] < 0)
                rs_d[c] = '0;
            so_d[c] = sat_out(rs_d[c]);
            data_d1[c*OUTW +: OUTW] = so_d[c][OUTW-1:0];
            sat_d1 = sat_d1 | so_d[c][OUTW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLUMN; c++)
                acc_q[c] <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            acc_sat_q <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            for (int c = 0; c < COLUMN; c++)
                acc_q[c] <= acc_d[c];
            acc_sat_q <= acc_sat_d;
            vld_p0    <= last_acc;
            vld_p1    <= vld_p0;
            // Stage p1 -> FIFO
            if (vld_p1) begin
                mem_q[wr_ptr_q] <= {sat_p1, data_p1};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (fifo_rd)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({vld_p1, fifo_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Data pipeline registers carry no reset; vld_p0/vld_p1 qualify them.
    always_ff @(posedge clk) begin
        if (last_acc) begin
            sum_p0   <= sum_d;
            shift_p0 <= shift;
            relu_p0  <= relu_en;
            sat_p0   <= |acc_sat_d;
        end
        if (vld_p0) begin
            data_p1 <= data_d1;
            sat_p1  <= sat_d1;
        end
    end

endmodule

// File: tb/tb_mac_psum_acc.sv
module tb_mac_psum_acc;
    localparam int COLUMN = 6;
    localparam int IW     = 24;
    localparam int BW     = 24;
    localparam int OUTW   = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [COLUMN*IW-1:0]   acc_m_data = '0;
    logic                   acc_m_first = 1'b0, acc_m_last = 1'b0, acc_m_valid = 1'b0;
    logic                   acc_m_ready;
    logic [COLUMN*BW-1:0]   bias = '0;
    logic [4:0]             shift = '0;
    logic                   relu_en = 1'b0;
    logic [COLUMN*OUTW-1:0] acc_s_data;
    logic                   acc_s_sat, acc_s_valid;
    logic                   acc_s_ready = 1'b1;

    always #5 clk = ~clk;

    mac_psum_acc dut (
        .clk(clk), .rst_n(rst_n),
        .acc_m_data(acc_m_data), .acc_m_first(acc_m_first), .acc_m_last(acc_m_last),
        .acc_m_valid(acc_m_valid), .acc_m_ready(acc_m_ready),
        .bias(bias), .shift(shift), .relu_en(relu_en),
        .acc_s_data(acc_s_data), .acc_s_sat(acc_s_sat),
        .acc_s_valid(acc_s_valid), .acc_s_ready(acc_s_ready)
    );

    int n_chk = 0;
    int n_pass = 0;
    int pops = 0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    typedef struct { logic [COLUMN*OUTW-1:0] data; logic sat; } res_t;
    res_t   exp_q[$];
    res_t   mon_e;
    longint m_acc [COLUMN];
    bit     m_sat;

    function automatic res_t model_result();
        res_t r;
        longint s, d, q;
        logic signed [BW-1:0] b;
        r.data = '0;
        r.sat  = m_sat;
        for (int c = 0; c < COLUMN; c++) begin
            b = bias[c*BW +: BW];
            s = m_acc[c] + longint'(b);
            if (shift != 0) begin
                d = longint'(1) << shift;
                s = s + d / 2;
                q = s / d;
                if ((s % d) != 0 && s < 0) q = q - 1;   // floor division
                s = q;
            end
            if (relu_en && s < 0) s = 0;
            if (s > 127) begin s = 127; r.sat = 1'b1; end
            else if (s < -128) begin s = -128; r.sat = 1'b1; end
            r.data[c*OUTW +: OUTW] = s[7:0];
        end
        return r;
    endfunction

    task automatic model_beat();
        logic signed [IW-1:0] l;
        if (acc_m_first) m_sat = 1'b0;
        for (int c = 0; c < COLUMN; c++) begin
            l = acc_m_data[c*IW +: IW];
            if (acc_m_first) m_acc[c] = longint'(l);
            else begin
                m_acc[c] = m_acc[c] + longint'(l);
                if (m_acc[c] > 64'sd2147483647) begin m_acc[c] = 64'sd2147483647; m_sat = 1'b1; end
                if (m_acc[c] < -64'sd2147483648) begin m_acc[c] = -64'sd2147483648; m_sat = 1'b1; end
            end
        end
        if (acc_m_last) exp_q.push_back(model_result());
    endtask

    // Scoreboard: every handshake on the result side is compared in order.
    always @(negedge clk) begin
        if (rst_n && acc_s_valid && acc_s_ready) begin
            chk("mon_result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("mon_data", 64'(acc_s_data), 64'(mon_e.data));
                chk("mon_sat", 64'(acc_s_sat), 64'(mon_e.sat));
                pops++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [COLUMN*IW-1:0] all_lanes(input int v);
        logic [COLUMN*IW-1:0] r;
        for (int c = 0; c < COLUMN; c++) r[c*IW +: IW] = v[IW-1:0];
        return r;
    endfunction

    function automatic logic [COLUMN*BW-1:0] all_bias(input int v);
        logic [COLUMN*BW-1:0] r;
        for (int c = 0; c < COLUMN; c++) r[c*BW +: BW] = v[BW-1:0];
        return r;
    endfunction

    function automatic logic [COLUMN*IW-1:0] two_lanes(input int a, input int b);
        logic [COLUMN*IW-1:0] r;
        r = '0;
        r[IW-1:0]    = a[IW-1:0];
        r[2*IW-1:IW] = b[IW-1:0];
        return r;
    endfunction

    task automatic send_beat(input logic [COLUMN*IW-1:0] d, input bit first, input bit last,
                             input int max_cyc, output bit ok);
        acc_m_data  = d;
        acc_m_first = first;
        acc_m_last  = last;
        acc_m_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (rnd_ready) acc_s_ready = ($urandom_range(0, 3) != 0);
            if (acc_m_ready) begin
                model_beat();
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        acc_m_valid = 1'b0;
    endtask

    task automatic beat(input logic [COLUMN*IW-1:0] d, input bit first, input bit last);
        bit ok;
        send_beat(d, first, last, 200, ok);
        if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_post(input int b, input int sh, input bit r);
        bias = all_bias(b); shift = 5'(sh); relu_en = r;
    endtask

    typedef struct { int val; int bs; int sh; bit relu; logic [7:0] eo; bit es; } vec_t;
    vec_t tbl [16];

    initial begin
        bit ok;
        int n_acc, pops0;
        logic [COLUMN*IW-1:0] rd;

        // value, bias, shift, relu, expected lane output, expected sat
        tbl[0]  = '{-12,        0,  0, 1'b1, 8'h00, 1'b0};
        tbl[1]  = '{-12,        0,  0, 1'b0, 8'hF4, 1'b0};
        tbl[2]  = '{5,          3,  1, 1'b0, 8'h04, 1'b0};
        tbl[3]  = '{-5,         0,  1, 1'b0, 8'hFE, 1'b0};
        tbl[4]  = '{-3,         0,  1, 1'b0, 8'hFF, 1'b0};
        tbl[5]  = '{127,        0,  0, 1'b0, 8'h7F, 1'b0};
        tbl[6]  = '{128,        0,  0, 1'b0, 8'h7F, 1'b1};
        tbl[7]  = '{-128,       0,  0, 1'b0, 8'h80, 1'b0};
        tbl[8]  = '{-129,       0,  0, 1'b0, 8'h80, 1'b1};
        tbl[9]  = '{1000,       24, 3, 1'b0, 8'h7F, 1'b1};
        tbl[10] = '{6,          0,  2, 1'b0, 8'h02, 1'b0};
        tbl[11] = '{-6,         0,  2, 1'b0, 8'hFF, 1'b0};
        tbl[12] = '{50,         0,  0, 1'b1, 8'h32, 1'b0};
        tbl[13] = '{-1000,      0,  3, 1'b1, 8'h00, 1'b0};
        tbl[14] = '{8388607,    0,  0, 1'b0, 8'h7F, 1'b1};
        tbl[15] = '{-8388608, -8388608, 20, 1'b0, 8'hF0, 1'b0};

        // Reset state
        cycles(3);
        chk("rst_s_valid", 64'(acc_s_valid), 64'd0);
        chk("rst_s_data", 64'(acc_s_data), 64'd0);
        chk("rst_s_sat", 64'(acc_s_sat), 64'd0);
        chk("rst_m_ready", 64'(acc_m_ready), 64'd1);
        rst_n = 1'b1;
        cycles(2);

        // Three-beat group: lane0 10+20+30+4 -> 16, lane1 -600 -> -128 (sat)
        bias = '0; bias[BW-1:0] = 24'd4; shift = 5'd2; relu_en = 1'b0;
        beat(two_lanes(10, -300), 1'b1, 1'b0);
        beat(two_lanes(20, -200), 1'b0, 1'b0);
        beat(two_lanes(30, -100), 1'b0, 1'b1);
        cycles(1);
        chk("lat_not_yet_valid", 64'(acc_s_valid), 64'd0);
        cycles(1);
        chk("lat_valid", 64'(acc_s_valid), 64'd1);
        chk("grp_data", 64'(acc_s_data), 64'h0000_0000_8010);
        chk("grp_sat", 64'(acc_s_sat), 64'd1);
        cycles(1);

        // Single-beat vector table
        for (int i = 0; i < 16; i++) begin
            set_post(tbl[i].bs, tbl[i].sh, tbl[i].relu);
            beat(all_lanes(tbl[i].val), 1'b1, 1'b1);
            cycles(2);
            chk($sformatf("tbl%0d_valid", i), 64'(acc_s_valid), 64'd1);
            chk($sformatf("tbl%0d_data", i), 64'(acc_s_data), 64'({COLUMN{tbl[i].eo}}));
            chk($sformatf("tbl%0d_sat", i), 64'(acc_s_sat), 64'(tbl[i].es));
        end
        cycles(2);

        // Backpressure: only DEPTH groups get in while the sink stalls
        set_post(0, 0, 1'b0);
        acc_s_ready = 1'b0;
        pops0 = pops;
        n_acc = 0;
        for (int k = 1; k <= 6; k++) begin
            send_beat(all_lanes(k), 1'b1, 1'b1, 3, ok);
            if (!ok) break;
            n_acc++;
        end
        chk("bp_accepted", 64'(n_acc), 64'd4);
        cycles(3);
        chk("bp_m_ready_low", 64'(acc_m_ready), 64'd0);
        chk("bp_head_stable", 64'(acc_s_data), 64'({COLUMN{8'd1}}));
        acc_s_ready = 1'b1;
        beat(all_lanes(5), 1'b1, 1'b1);
        beat(all_lanes(6), 1'b1, 1'b1);
        cycles(8);
        chk("bp_drained", 64'(pops - pops0), 64'd6);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Accumulator saturation: 300 x (2^23-1) clamps at 2^31-1
        set_post(0, 0, 1'b0);
        for (int i = 0; i < 300; i++)
            beat(two_lanes(8388607, 0), i == 0, i == 299);
        cycles(2);
        chk("accsat_data", 64'(acc_s_data), 64'h0000_0000_007F);
        chk("accsat_sat", 64'(acc_s_sat), 64'd1);
        cycles(2);

        // Reset in the middle of a group with two results queued
        acc_s_ready = 1'b0;
        beat(all_lanes(7), 1'b1, 1'b1);
        beat(all_lanes(8), 1'b1, 1'b1);
        beat(all_lanes(9), 1'b1, 1'b0);
        beat(all_lanes(9), 1'b0, 1'b0);
        cycles(2);
        chk("mid_pre_valid", 64'(acc_s_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(acc_s_valid), 64'd0);
        chk("mid_rst_ready", 64'(acc_m_ready), 64'd1);
        chk("mid_rst_data", 64'(acc_s_data), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_s_ready = 1'b1;
        beat(all_lanes(5), 1'b1, 1'b0);
        beat(all_lanes(5), 1'b0, 1'b1);
        cycles(2);
        chk("mid_new_valid", 64'(acc_s_valid), 64'd1);
        chk("mid_new_data", 64'(acc_s_data), 64'({COLUMN{8'd10}}));
        cycles(2);

        // FIFO read and write on the same edge with two entries held
        acc_s_ready = 1'b0;
        beat(all_lanes(21), 1'b1, 1'b1);
        beat(all_lanes(22), 1'b1, 1'b1);
        cycles(3);
        beat(all_lanes(23), 1'b1, 1'b1);
        chk("rw_head0", 64'(acc_s_data), 64'({COLUMN{8'd21}}));
        acc_s_ready = 1'b1;
        cycles(1);
        chk("rw_head1", 64'(acc_s_data), 64'({COLUMN{8'd22}}));
        cycles(1);
        chk("rw_head2_valid", 64'(acc_s_valid), 64'd1);
        chk("rw_head2", 64'(acc_s_data), 64'({COLUMN{8'd23}}));
        cycles(1);
        chk("rw_empty", 64'(acc_s_valid), 64'd0);

        // Randomized groups with random sink stalls
        rnd_ready = 1'b1;
        for (int g = 0; g < 60; g++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int c = 0; c < COLUMN; c++) bias[c*BW +: BW] = BW'($urandom);
            shift   = 5'($urandom_range(0, 20));
            relu_en = $urandom_range(0, 1) != 0;
            for (int b = 0; b < len; b++) begin
                for (int c = 0; c < COLUMN; c++) rd[c*IW +: IW] = IW'($urandom);
                beat(rd, b == 0, b == len - 1);
            end
        end
        rnd_ready = 1'b0;
        acc_s_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycles(1);
        cycles(2);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_s_valid", 64'(acc_s_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_psum_acc.md
Name: mac_psum_acc

Overview:
- Output stage directly downstream of the systolic MAC array. It consumes the per-column partial-sum beats (COLUMN lanes of IW signed bits) carried with first/last/valid framing.
- Per column it accumulates all beats of one group (input-channel tiles), adds a per-column bias, then applies a rounding arithmetic right shift, optional ReLU and saturation to OUTW bits.
- Each finished group is queued in a DEPTH-entry output FIFO with valid/ready handshake toward the writeback stage.

Parameters:
- COLUMN, 6, number of array columns / lanes
- IW, 24, signed width of each input lane (array output width)
- BW, 24, signed width of each bias lane
- AW, 32, signed accumulator width per lane
- OUTW, 8, signed width of each output lane
- DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- acc_m_data  in  COLUMN*IW  partial sums, lane c at [c*IW +: IW], signed
- acc_m_first  in  1  first beat of group
- acc_m_last  in  1  last beat of group
- acc_m_valid  in  1  beat valid
- acc_m_ready  out  1  beat accepted when valid&&ready
- bias  in  COLUMN*BW  per-lane signed bias, sampled on accepted last beat
- shift  in  5  right-shift amount, sampled on accepted last beat
- relu_en  in  1  clamp negatives to 0, sampled on accepted last beat
- acc_s_data  out  COLUMN*OUTW  result lanes, lane c at [c*OUTW +: OUTW]
- acc_s_sat  out  1  any lane saturated (accumulator or output) in this group
- acc_s_valid  out  1  result valid
- acc_s_ready  in  1  downstream accept

Behaviour:
- Reset (async, rst_n low):
  - acc regs = 0; acc sat flags = 0; post-stage valid = 0.
  - FIFO empty: pointers and count = 0.
  - Outputs: acc_s_valid = 0, acc_s_data = 0, acc_s_sat = 0, acc_m_ready = 1.
  - In-flight groups are discarded; the next accepted beat must carry first.
- acc_m_ready = (fifo_count + post_valid) < DEPTH. This is registered-state based only and has no combinational path from acc_s_ready.
- Accumulate stage, on an accepted beat, per lane:
  - Input sign-extended to AW.
  - first=1: acc = in. first=0: acc = acc + in, saturating at the AW signed max/min, and that lane's sat flag is set.
  - first=1 clears all sat flags before this beat's update.
  - first&&last together: single-beat group, acc = in.
  - Non-first beat after a completed group: adds to the stale acc. This is not checked; framing is the upstream stage's responsibility.
- Post stage, loaded on the edge accepting a last beat, from the updated acc value:
  - sum = acc + sext(bias), computed in AW+1 bits.
  - If shift>0: sum = (sum + 2^(shift-1)) >>> shift (round half up). If shift=0: no rounding, no shift.
  - If relu_en and sum<0: sum = 0.
  - Saturate to OUTW signed range [-2^(OUTW-1), 2^(OUTW-1)-1]. Saturation sets the group sat bit, which is OR-ed with the accumulator sat flags.
  - post_valid = 1 for exactly one cycle.
  - The post stage can never overflow the FIFO, by the ready rule above.
- FIFO:
  - Written on the cycle post_valid=1. Read when acc_s_valid&&acc_s_ready.
  - Simultaneous read+write with count=DEPTH is impossible. Simultaneous read+write otherwise: count unchanged.
  - acc_s_data/acc_s_sat show the head entry, driven from registers. acc_s_valid = (count != 0).
  - Order is preserved.
- Latency: last beat accepted at edge E; acc_s_valid high after edge E+2 when the FIFO was empty.
- Throughput: one beat per cycle. With acc_s_ready held 1, single-beat groups stream at one result per cycle.
- acc_s_data and acc_s_sat stay stable while acc_s_valid=1 and acc_s_ready=0.

Test Plan:
- Accumulate/round/sat: lane0 beats 10,20,30 (first on 10, last on 30), bias0=4, shift=2, relu_en=0; lane1 beats -100,-50,0, bias1=0.
  - Lane0: 64 -> (64+2)>>>2 = 16. Lane1: -150 -> -128.
  - acc_s_sat=1; acc_s_valid two edges after the last beat is accepted.
- ReLU and shift=0: single first&&last beat, lane0=-12, bias=0, relu_en=1 -> lane0=0, acc_s_sat=0. Same stimulus with relu_en=0 -> lane0=-12 (0xF4).
- Backpressure: acc_s_ready=0, offer 6 single-beat groups with values 1..6.
  - Exactly 4 are accepted, then acc_m_ready=0.
  - Raising acc_s_ready drains 1,2,3,4 in order, then 5 and 6 are accepted; no loss or duplication.
- Accumulator saturation: 300 beats of lane0=+2^23-1 in one group -> acc clamps at 2^31-1; output 127; acc_s_sat=1.
- Reset mid-operation: assert rst_n low after 2 beats of a 3-beat group with 2 results queued.
  - acc_s_valid falls to 0 immediately; acc_m_ready=1.
  - A new group 5,5 (bias 0, shift 0) yields exactly 10.
- Simultaneous FIFO read/write: count=2 with acc_s_ready=1 while a new last beat completes -> count stays 2 and order is correct.
